// File: rtl/io_timer_pkg.sv
// io_timer shared definitions: register offsets, field positions, write masks.
package io_timer_pkg;

  // Register offsets, selected by byte address bits [2:1]
  localparam logic [1:0] TMR_OFF_CTRL  = 2'd0;
  localparam logic [1:0] TMR_OFF_COUNT = 2'd1;
  localparam logic [1:0] TMR_OFF_CMP   = 2'd2;
  localparam logic [1:0] TMR_OFF_STAT  = 2'd3;

  // CTRL field positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AR        = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_PRESC_LSB = 8;

  // STAT field positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_W     = 2;

  // CTRL write mask: bits [7:3] are held at zero
  localparam logic [15:0] CTRL_WMASK = 16'hFF07;

  localparam logic [15:0] CMP_RESET = 16'hFFFF;

endpackage

// File: rtl/io_timer_if.sv
// CPU I/O data-bus connection for one responder (address, strobes, data, ready).
interface io_timer_if;
  logic        i_sel;
  logic [15:0] i_addr;
  logic        i_we;
  logic        i_re;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_rdy;

  modport master (
    output i_sel, i_addr, i_we, i_re, i_wdata,
    input  o_rdata, o_rdy
  );

  modport slave (
    input  i_sel, i_addr, i_we, i_re, i_wdata,
    output o_rdata, o_rdy
  );
endinterface

// File: rtl/io_timer_prescaler.sv
// Prescaler: divides the clock by (PRESC+1) while enabled, producing one-cycle ticks.
module io_timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_restart,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_p_cnt;

  assign o_tick = i_en & (r_p_cnt == i_presc);

  // Count 0..PRESC, wrapping on a tick; parked at zero when disabled or restarted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_cnt <= '0;
    end else if (~i_en | i_restart | o_tick) begin
      r_p_cnt <= '0;
    end else begin
      r_p_cnt <= r_p_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: memory-mapped 16-bit timer/compare responder with one-wait-state loads.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8100,
  parameter int          PRESC_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  io_timer_if.slave   bus,
  output logic        o_irq
);

  logic [15:0]       r_ctrl;
  logic [15:0]       r_count;
  logic [15:0]       r_cmp;
  logic [STAT_W-1:0] r_stat;
  logic              r_rd_pend;
  logic [15:0]       r_rdata_q;

  logic              w_hit;
  logic [1:0]        w_off;
  logic              w_store;
  logic              w_rd_req;
  logic              w_tick;
  logic              w_restart;
  logic [15:0]       w_count_next;
  logic [STAT_W-1:0] w_stat_set;
  logic [STAT_W-1:0] w_stat_clr;
  logic [15:0]       w_rd_val;
  logic              w_unused;

  // Byte-lane bit of the address is irrelevant for word registers
  assign w_unused = bus.i_addr[0];

  assign w_hit    = bus.i_sel & (bus.i_addr[15:3] == BASE_ADDR[15:3]);
  assign w_off    = bus.i_addr[2:1];
  // A strobe with both we and re is a store
  assign w_store  = w_hit & bus.i_we;
  // Gated by reset so a load in flight is abandoned cleanly
  assign w_rd_req = w_hit & bus.i_re & ~bus.i_we & ~i_rst;

  // A new divide value restarts the prescaler phase
  assign w_restart = w_store & (w_off == TMR_OFF_CTRL) &
                     (bus.i_wdata[CTRL_PRESC_LSB +: PRESC_W] != r_ctrl[CTRL_PRESC_LSB +: PRESC_W]);

  io_timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (r_ctrl[CTRL_EN]),
    .i_presc   (r_ctrl[CTRL_PRESC_LSB +: PRESC_W]),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Next count and hardware status events; a CPU write of COUNT overrides the tick
  always_comb begin
    w_count_next = r_count;
    w_stat_set   = '0;
    if (w_tick) begin
      if (r_count == r_cmp) begin
        w_stat_set[STAT_MATCH] = 1'b1;
        if (r_ctrl[CTRL_AR]) begin
          w_count_next = '0;
        end else begin
          w_count_next          = r_count + 16'd1;
          w_stat_set[STAT_OVF]  = (r_count == 16'hFFFF);
        end
      end else if (r_count == 16'hFFFF) begin
        w_count_next         = '0;
        w_stat_set[STAT_OVF] = 1'b1;
      end else begin
        w_count_next = r_count + 16'd1;
      end
    end
    if (w_store && (w_off == TMR_OFF_COUNT)) begin
      w_count_next = bus.i_wdata;
    end
  end

  assign w_stat_clr = (w_store && (w_off == TMR_OFF_STAT)) ? bus.i_wdata[STAT_W-1:0] : '0;

  // Control, count and compare registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl  <= '0;
      r_count <= '0;
      r_cmp   <= CMP_RESET;
    end else begin
      r_count <= w_count_next;
      if (w_store && (w_off == TMR_OFF_CTRL)) begin
        r_ctrl <= bus.i_wdata & CTRL_WMASK;
      end
      if (w_store && (w_off == TMR_OFF_CMP)) begin
        r_cmp <= bus.i_wdata;
      end
    end
  end

  // Sticky status bits: write-1-to-clear, a simultaneous hardware set wins
  for (genvar gi = 0; gi < STAT_W; gi++) begin : g_stat
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_stat[gi] <= 1'b0;
      end else begin
        r_stat[gi] <= (r_stat[gi] & ~w_stat_clr[gi]) | w_stat_set[gi];
      end
    end
  end

  // Read-side register select
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      TMR_OFF_CTRL:  w_rd_val = r_ctrl;
      TMR_OFF_COUNT: w_rd_val = r_count;
      TMR_OFF_CMP:   w_rd_val = r_cmp;
      default:       w_rd_val = {{(16-STAT_W){1'b0}}, r_stat};
    endcase
  end

  // Load pipeline: sample in the first cycle, present in the second
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pend <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      r_rd_pend <= w_rd_req & ~r_rd_pend;
      if (w_rd_req & ~r_rd_pend) begin
        r_rdata_q <= w_rd_val;
      end
    end
  end

  assign bus.o_rdy   = ~w_rd_req | r_rd_pend;
  assign bus.o_rdata = (r_rd_pend & ~i_rst) ? r_rdata_q : 16'h0000;
  assign o_irq       = r_ctrl[CTRL_IRQ_EN] & r_stat[STAT_MATCH];

endmodule
